vram_arbiter: RTL

// - Shares the single-port synchronous video RAM between the Z8 CPU bus and the video scanout fetcher.
// - Sits inside SoC between the CPU memory decode (video RAM window) and the RAM macro; the scanout side feeds videoPixel.
// - Grants one access per clk; video has priority by default, CPU gets a req/ack wait-state handshake.

---
 rtl/vram_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port video RAM between the Z8 CPU bus and the scanout fetcher.
// Define VRAM_ARB_FAIRNESS_EN to let a long-waiting CPU override video priority.
module vram_arbiter #(
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned MAX_CPU_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpuReq,
    input  logic              cpuWe,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [DATA_W-1:0] cpuWData,
    output logic [DATA_W-1:0] cpuRData,
    output logic              cpuAck,
    input  logic              vidReq,
    input  logic [ADDR_W-1:0] vidAddr,
    output logic [DATA_W-1:0] vidRData,
    output logic              vidValid,
    output logic [ADDR_W-1:0] ramAddr,
    output logic [DATA_W-1:0] ramWData,
    output logic              ramWe,
    input  logic [DATA_W-1:0] ramRData
);

    if (MAX_CPU_WAIT < 1 || MAX_CPU_WAIT > 15) begin : g_bad_max_cpu_wait
        $error("vram_arbiter: MAX_CPU_WAIT must be in 1..15");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_VID = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              vid_valid_q, vid_valid_d;

    // A grant always completes on the following edge, so the in-flight flags are the grant state itself.
    logic cpu_inflight, vid_inflight;
    logic cpu_elig, vid_elig;
    logic cpu_force;
    logic grant_cpu, grant_vid;

    assign cpu_inflight = (state_q == GNT_CPU);
    assign vid_inflight = (state_q == GNT_VID);
    assign cpu_elig     = cpuReq && !cpu_inflight;
    assign vid_elig     = vidReq && !vid_inflight;
    assign grant_cpu    = cpu_elig && (!vid_elig || cpu_force);
    assign grant_vid    = vid_elig && !grant_cpu;

`ifdef VRAM_ARB_FAIRNESS_EN
    logic [3:0] wait_q, wait_d;

    assign cpu_force = cpu_elig && (wait_q == 4'(MAX_CPU_WAIT));

    always_comb begin
        wait_d = wait_q;
        if (!cpuReq || grant_cpu) begin
            wait_d = '0;
        end else if (cpu_elig && (wait_q != 4'(MAX_CPU_WAIT))) begin
            wait_d = wait_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    assign cpu_force = 1'b0;
`endif

    always_comb begin
        state_d     = IDLE;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        vid_rdata_d = vid_rdata_q;
        cpu_ack_d   = 1'b0;
        vid_valid_d = 1'b0;

        case (state_q)
            GNT_VID: begin
                vid_rdata_d = ramRData;
                vid_valid_d = 1'b1;
            end
            GNT_CPU: begin
                cpu_ack_d = 1'b1;
                if (!ram_we_q) begin
                    cpu_rdata_d = ramRData;
                end
            end
            default: ;
        endcase

        if (grant_vid) begin
            state_d    = GNT_VID;
            ram_addr_d = vidAddr;
        end else if (grant_cpu) begin
            state_d     = GNT_CPU;
            ram_addr_d  = cpuAddr;
            ram_wdata_d = cpuWData;
            ram_we_d    = cpuWe;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            cpu_rdata_q <= '0;
            vid_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            vid_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            cpu_rdata_q <= cpu_rdata_d;
            vid_rdata_q <= vid_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            vid_valid_q <= vid_valid_d;
        end
    end

    assign ramAddr  = ram_addr_q;
    assign ramWData = ram_wdata_q;
    assign ramWe    = ram_we_q;
    assign cpuRData = cpu_rdata_q;
    assign vidRData = vid_rdata_q;
    assign cpuAck   = cpu_ack_q;
    assign vidValid = vid_valid_q;

endmodule
